avmm_reg_bank: RTL
==================

// Module: avmm_reg_bank
// PURPOSE
//  Avalon-MM slave register bank: the bus-facing read/write end of our enabled-register primitives.
//  Nios writes control registers that drive hardware, and reads back control, status and capture registers.
//  Status bits are sticky hardware events with write-1-to-clear; a masked OR of status drives a registered IRQ.
//  Sits between the Qsys interconnect and datapath blocks in the custom peripherals.
// PARAMETERS
//  S       12  data width of every register and of avs_writedata / avs_readdata
//  N_CTRL  4   number of RW control registers, 1..8
//  AW      3   address width; 2**AW >= N_CTRL+3
// PORTS
//  CLK               in   1          clock, all state on rising edge
//  CLR               in   1          asynchronous active-high reset/clear
//  avs_address       in   AW         word address
//  avs_read          in   1          read request, one-cycle strobe, no waitrequest
//  avs_write         in   1          write request, one-cycle strobe, no waitrequest
//  avs_writedata     in   S          write data
//  avs_readdata      out  S          read data, valid with avs_readdatavalid
//  avs_readdatavalid out  1          high exactly one cycle after each accepted read
//  hw_event          in   S          per-bit event pulses, set STAT bits
//  hw_capture        in   1          load hw_data into CAP
//  hw_data           in   S          capture source
//  ctrl_out          out  N_CTRL*S   control registers, reg i at [i*S +: S]
//  irq               out  1          registered interrupt, level
// BEHAVIOUR
//  Map: addr 0..N_CTRL-1 = CTRL[i] (RW); N_CTRL = STAT (R, W1C); N_CTRL+1 = MASK (RW); N_CTRL+2 = CAP (RO).
//  Unmapped address: write ignored; read returns 0 with normal readdatavalid.
//  Reset (CLR high, async): CTRL, STAT, MASK, CAP, avs_readdata, avs_readdatavalid and irq all go to 0 immediately.
//  Write: at the edge where avs_write=1, the target register takes avs_writedata; visible on ctrl_out the next cycle.
//  Read latency is fixed at 1. At the edge where avs_read=1, avs_readdata <= register value; avs_readdatavalid <= 1.
//  When no read is accepted, avs_readdatavalid <= 0 and avs_readdata holds its last value.
//  A read samples pre-edge values. Read and write to the same address in the same cycle returns the OLD value.
//  Back-to-back reads on consecutive cycles give consecutive valid cycles, one datum each.
//  STAT next = (STAT & ~(wr_stat ? avs_writedata : 0)) | hw_event.
//   hw_event set wins over a simultaneous W1C on the same bit. Bits not written 1 are untouched.
//  CAP: when hw_capture=1, CAP <= hw_data. Bus writes to CAP are ignored. A read in the capture cycle returns the old CAP.
//  irq <= |(STAT_next & MASK_next): registered, asserted one cycle after the causing event or mask write.
//   irq deasserts one cycle after the clearing W1C or mask write.
//  CLR asserted mid-transaction: the pending readdatavalid is dropped (no valid pulse after reset).
//   Accesses in the first cycle after CLR release are handled normally.
//  All arithmetic is bitwise; no width extension. Writedata bits above S do not exist.
// TESTING
//  (S=12, N_CTRL=4, AW=3)
//  Reset: pulse CLR mid-cycle during a read -> all outputs 0 asynchronously; no readdatavalid after the release.
//  Write 0xA5C to addr 2, then read addr 2 -> ctrl_out[35:24]=0xA5C next cycle; readdata=0xA5C with valid 1 cycle after the read.
//  hw_event=0x011 for 1 cycle, MASK=0x001 -> STAT=0x011 and irq=1 one cycle later.
//   Write 0x001 to addr 4 -> STAT=0x010 and irq=0.
//  Same cycle: hw_event=0x004 and W1C 0x004 -> STAT bit 2 stays 1.
//   Write addr 1 =0x123 plus read addr 1 in the same cycle, old value 0x000 -> readdata 0x000, then a re-read returns 0x123.
//  hw_capture with hw_data=0xFFF plus bus write 0x000 to addr 6 -> CAP reads 0xFFF.
//   Read addr 7 (unmapped) -> 0x000 with valid.
//  Reads on 3 consecutive cycles to addrs 0,5,6 -> 3 consecutive valid cycles with the matching data, in order.

Source files
------------

// File: rtl/avmm_reg_bank.sv
// Avalon-MM slave register bank.
// Holds N_CTRL read/write control registers, a sticky write-1-to-clear status
// register, an interrupt mask and a hardware capture register. Reads have a
// fixed one-cycle latency and always return the values held before the edge.
// The interrupt output is a registered, masked OR of the status bits.
module avmm_reg_bank #(
    parameter int S      = 12,
    parameter int N_CTRL = 4,
    parameter int AW     = 3
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic [AW-1:0]         avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [S-1:0]          avs_writedata,
    output logic [S-1:0]          avs_readdata,
    output logic                  avs_readdatavalid,
    input  logic [S-1:0]          hw_event,
    input  logic                  hw_capture,
    input  logic [S-1:0]          hw_data,
    output logic [N_CTRL*S-1:0]   ctrl_out,
    output logic                  irq
);

    // Register map: control registers first, then status, mask and capture.
    localparam logic [AW-1:0] A_STAT = AW'(N_CTRL);
    localparam logic [AW-1:0] A_MASK = AW'(N_CTRL + 1);
    localparam logic [AW-1:0] A_CAP  = AW'(N_CTRL + 2);

    logic [N_CTRL*S-1:0] ctrl_q, ctrl_d;
    logic [S-1:0]        stat_q, stat_d;
    logic [S-1:0]        mask_q, mask_d;
    logic [S-1:0]        cap_q,  cap_d;
    logic [S-1:0]        rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                irq_q, irq_d;
    logic [S-1:0]        rd_val;
    logic [S-1:0]        w1c_bits;

    // Read mux over the current (pre-edge) register values; unmapped reads return 0.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_CTRL; i++) begin
            if (avs_address == AW'(i)) begin
                rd_val = ctrl_q[i*S +: S];
            end
        end
        if (avs_address == A_STAT) rd_val = stat_q;
        if (avs_address == A_MASK) rd_val = mask_q;
        if (avs_address == A_CAP)  rd_val = cap_q;
    end

    // Next-state logic for all registers, bus response and interrupt.
    always_comb begin
        ctrl_d   = ctrl_q;
        mask_d   = mask_q;
        cap_d    = cap_q;
        w1c_bits = '0;
        for (int i = 0; i < N_CTRL; i++) begin
            if (avs_write && (avs_address == AW'(i))) begin
                ctrl_d[i*S +: S] = avs_writedata;
            end
        end
        if (avs_write && (avs_address == A_MASK)) mask_d = avs_writedata;
        if (avs_write && (avs_address == A_STAT)) w1c_bits = avs_writedata;
        // Event set is applied after the clear so a simultaneous event wins.
        stat_d = (stat_q & ~w1c_bits) | hw_event;
        // CAP is loaded only by hardware; bus writes to its address fall through.
        if (hw_capture) cap_d = hw_data;
        rdata_d  = avs_read ? rd_val : rdata_q;
        rvalid_d = avs_read;
        // irq looks at next-state values so it follows the causing edge by one cycle.
        irq_d    = |(stat_d & mask_d);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ctrl_q   <= '0;
            stat_q   <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            stat_q   <= stat_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign ctrl_out          = ctrl_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign irq               = irq_q;

endmodule
